// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter
//   Two-master arbiter for the shared peripheral bus (ADC slot 12, DAC slot 13,
//   DSP slot 14). Grants one transfer at a time to either the Leon-side master
//   or the equalizer controller (EC), then runs a setup/access transfer to the
//   selected slave and returns the read data to the owner in a DONE cycle.
//
// Ports
//   Clk, Reset_                       clock (rising edge), async active-low reset
//   ECOn                              equalizer enable; EReq ignored when low
//   LReq/LSel/LWrite/LAddr/LWData     Leon request fields (LSel one-hot {14,13,12})
//   LGnt/LDone/LRData                 Leon grant, completion pulse, read data
//   EReq/ESel/EWrite/EAddr/EWData     equalizer request fields
//   ELock                             equalizer keeps ownership across transfers
//   EGnt/EDone/ERData                 equalizer grant, completion pulse, read data
//   SSel12/13/14, SEnable, SWrite,
//   SAddr, SWData                     slave-side transfer signals
//   SRData12/13/14                    slave read data
//   Owner                             last granted master (0 = Leon, 1 = EC)
//
// All outputs decode only registered state; no input reaches an output
// without passing through a flop.

module periph_bus_arbiter #(
    parameter int MAX_WAIT = 8,
    parameter int CW       = 4
) (
    input  logic        Clk,
    input  logic        Reset_,
    input  logic        ECOn,
    input  logic        LReq,
    input  logic [2:0]  LSel,
    input  logic        LWrite,
    input  logic [31:0] LAddr,
    input  logic [31:0] LWData,
    output logic        LGnt,
    output logic        LDone,
    output logic [31:0] LRData,
    input  logic        EReq,
    input  logic [2:0]  ESel,
    input  logic        EWrite,
    input  logic [31:0] EAddr,
    input  logic [31:0] EWData,
    input  logic        ELock,
    output logic        EGnt,
    output logic        EDone,
    output logic [31:0] ERData,
    output logic        SSel12,
    output logic        SSel13,
    output logic        SSel14,
    output logic        SEnable,
    output logic        SWrite,
    output logic [31:0] SAddr,
    output logic [31:0] SWData,
    input  logic [31:0] SRData12,
    input  logic [31:0] SRData13,
    input  logic [31:0] SRData14,
    output logic        Owner
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t        state, state_nxt;
    logic          owner_q;
    logic [CW-1:0] wait_cnt;
    logic [2:0]    sel_q;
    logic          write_q;
    logic [31:0]   addr_q, wdata_q, rdata_q;

    logic          e_elig, grant_ec, grant_leon;
    logic          leon_gnt, xfer;
    logic [31:0]   rd_mux;

    assign e_elig   = EReq & ECOn;
    assign leon_gnt = (state != IDLE) & ~owner_q;
    assign xfer     = (state == SETUP) | (state == ACCESS);

    // Arbitration and next state. The lock term only applies while the EC
    // already owns the bus, which is why it outranks the starvation bound.
    always_comb begin
        state_nxt  = state;
        grant_ec   = 1'b0;
        grant_leon = 1'b0;
        case (state)
            IDLE: begin
                if (owner_q && ELock && e_elig)
                    grant_ec = 1'b1;
                else if (wait_cnt == CW'(MAX_WAIT) && LReq)
                    grant_leon = 1'b1;
                else if (e_elig)
                    grant_ec = 1'b1;
                else if (LReq)
                    grant_leon = 1'b1;
                if (grant_ec || grant_leon)
                    state_nxt = SETUP;
            end
            SETUP:   state_nxt = ACCESS;
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read-data select; writes and non-one-hot selects return zero.
    always_comb begin
        rd_mux = '0;
        if (!write_q) begin
            case (sel_q)
                3'b001:  rd_mux = SRData12;
                3'b010:  rd_mux = SRData13;
                3'b100:  rd_mux = SRData14;
                default: rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_) begin
        if (!Reset_) begin
            state   <= IDLE;
            owner_q <= 1'b0;
            sel_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (grant_ec) begin
                owner_q <= 1'b1;
                sel_q   <= ESel;
                write_q <= EWrite;
                addr_q  <= EAddr;
                wdata_q <= EWData;
            end else if (grant_leon) begin
                owner_q <= 1'b0;
                sel_q   <= LSel;
                write_q <= LWrite;
                addr_q  <= LAddr;
                wdata_q <= LWData;
            end
            if (state == ACCESS)
                rdata_q <= rd_mux;
        end
    end

    // Leon starvation counter: counts only while the EC is enabled and Leon
    // is asking without holding the bus.
    always_ff @(posedge Clk or negedge Reset_) begin
        if (!Reset_)
            wait_cnt <= '0;
        else if (!LReq || grant_leon)
            wait_cnt <= '0;
        else if (ECOn && !leon_gnt && wait_cnt != CW'(MAX_WAIT))
            wait_cnt <= wait_cnt + 1'b1;
    end

    assign SSel12  = xfer & (sel_q == 3'b001);
    assign SSel13  = xfer & (sel_q == 3'b010);
    assign SSel14  = xfer & (sel_q == 3'b100);
    assign SEnable = (state == ACCESS);
    assign SWrite  = xfer & write_q;
    assign SAddr   = xfer ? addr_q  : '0;
    assign SWData  = xfer ? wdata_q : '0;

    assign LGnt   = leon_gnt;
    assign EGnt   = (state != IDLE) & owner_q;
    assign LDone  = (state == DONE) & ~owner_q;
    assign EDone  = (state == DONE) & owner_q;
    assign LRData = LDone ? rdata_q : '0;
    assign ERData = EDone ? rdata_q : '0;
    assign Owner  = owner_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// tb_periph_bus_arbiter
//   Directed bench for periph_bus_arbiter. A transfer-level reference model
//   (phase number of the current transfer plus the recorded request) predicts
//   every output each cycle; directed scenarios add hand-computed completion
//   cycles and read-data values.

module tb_periph_bus_arbiter;

    localparam int MAX_WAIT = 8;

    logic        Clk, Reset_, ECOn;
    logic        LReq, LWrite, EReq, EWrite, ELock;
    logic [2:0]  LSel, ESel;
    logic [31:0] LAddr, LWData, EAddr, EWData;
    logic        LGnt, LDone, EGnt, EDone;
    logic [31:0] LRData, ERData;
    logic        SSel12, SSel13, SSel14, SEnable, SWrite;
    logic [31:0] SAddr, SWData;
    logic [31:0] SRData12, SRData13, SRData14;
    logic        Owner;

    periph_bus_arbiter #(.MAX_WAIT(MAX_WAIT), .CW(4)) dut (
        .Clk(Clk), .Reset_(Reset_), .ECOn(ECOn),
        .LReq(LReq), .LSel(LSel), .LWrite(LWrite), .LAddr(LAddr), .LWData(LWData),
        .LGnt(LGnt), .LDone(LDone), .LRData(LRData),
        .EReq(EReq), .ESel(ESel), .EWrite(EWrite), .EAddr(EAddr), .EWData(EWData),
        .ELock(ELock), .EGnt(EGnt), .EDone(EDone), .ERData(ERData),
        .SSel12(SSel12), .SSel13(SSel13), .SSel14(SSel14), .SEnable(SEnable),
        .SWrite(SWrite), .SAddr(SAddr), .SWData(SWData),
        .SRData12(SRData12), .SRData13(SRData13), .SRData14(SRData14),
        .Owner(Owner)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int cyc;
    always @(posedge Clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // phase: 0 = no transfer, 1 = setup, 2 = access, 3 = done
    typedef struct {
        int          phase;
        bit          who;
        int          wcnt;
        logic [2:0]  sel;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } mstate_t;

    mstate_t m;

    function automatic logic [31:0] slave_read(input mstate_t s);
        logic [31:0] bank [3];
        logic [31:0] r;
        bank[0] = SRData12;
        bank[1] = SRData13;
        bank[2] = SRData14;
        r = '0;
        if (!s.wr && $countones(s.sel) == 1)
            for (int i = 0; i < 3; i++)
                if (s.sel[i]) r = bank[i];
        return r;
    endfunction

    function automatic mstate_t model_next(input mstate_t s);
        mstate_t n;
        bit      e_ok;
        bit      leon_holds;
        int      win;
        n          = s;
        e_ok       = EReq && ECOn;
        leon_holds = (s.phase != 0) && !s.who;
        win        = -1;
        if (s.phase == 0) begin
            if (s.who && ELock && e_ok)           win = 1;
            else if (s.wcnt >= MAX_WAIT && LReq)  win = 0;
            else if (e_ok)                        win = 1;
            else if (LReq)                        win = 0;
            if (win >= 0) begin
                n.phase = 1;
                n.who   = (win == 1);
                if (win == 1) begin
                    n.sel = ESel; n.wr = EWrite; n.addr = EAddr; n.wdata = EWData;
                end else begin
                    n.sel = LSel; n.wr = LWrite; n.addr = LAddr; n.wdata = LWData;
                end
            end
        end else if (s.phase == 2) begin
            n.rdata = slave_read(s);
            n.phase = 3;
        end else begin
            n.phase = (s.phase + 1) % 4;
        end
        if (!LReq || win == 0)
            n.wcnt = 0;
        else if (ECOn && !leon_holds && s.wcnt < MAX_WAIT)
            n.wcnt = s.wcnt + 1;
        return n;
    endfunction

    always @(posedge Clk or negedge Reset_) begin
        if (!Reset_) m <= '{default: 0};
        else         m <= model_next(m);
    end

    // ---------------- checking ----------------
    int n_checks, n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        bit         busy, in_xfer, dn;
        logic [2:0] exp_sel;
        busy    = (m.phase != 0);
        in_xfer = (m.phase == 1) || (m.phase == 2);
        dn      = (m.phase == 3);
        exp_sel = (in_xfer && $countones(m.sel) == 1) ? m.sel : 3'b000;
        check("SSel12",  32'(SSel12),  32'(exp_sel[0]));
        check("SSel13",  32'(SSel13),  32'(exp_sel[1]));
        check("SSel14",  32'(SSel14),  32'(exp_sel[2]));
        check("SEnable", 32'(SEnable), 32'(m.phase == 2));
        check("LGnt",    32'(LGnt),    32'(busy && !m.who));
        check("EGnt",    32'(EGnt),    32'(busy && m.who));
        check("LDone",   32'(LDone),   32'(dn && !m.who));
        check("EDone",   32'(EDone),   32'(dn && m.who));
        check("Owner",   32'(Owner),   32'(m.who));
        if (busy || !Reset_) begin
            check("SWrite", 32'(SWrite), 32'(in_xfer && m.wr));
            check("SAddr",  SAddr,  in_xfer ? m.addr  : 32'h0);
            check("SWData", SWData, in_xfer ? m.wdata : 32'h0);
        end
        if (dn && !m.who) check("LRData", LRData, m.rdata);
        if (dn && m.who)  check("ERData", ERData, m.rdata);
        if (!Reset_) begin
            check("LRData_rst", LRData, 32'h0);
            check("ERData_rst", ERData, 32'h0);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    int          l_left, e_left;
    int          l_done_q[$], e_done_q[$];
    logic [31:0] l_data_q[$], e_data_q[$];
    bit          sen_seen, ssel_seen;
    int          start;

    // One clock: compare at the falling edge, record completions, then
    // release requests just after the edge that ends their Done cycle.
    task automatic step();
        bit saw_l, saw_e;
        @(negedge Clk);
        compare_all();
        saw_l = (LDone === 1'b1);
        saw_e = (EDone === 1'b1);
        if (saw_l) begin l_done_q.push_back(cyc); l_data_q.push_back(LRData); end
        if (saw_e) begin e_done_q.push_back(cyc); e_data_q.push_back(ERData); end
        if (SEnable === 1'b1) sen_seen = 1'b1;
        if ((SSel12 | SSel13 | SSel14) === 1'b1) ssel_seen = 1'b1;
        @(posedge Clk);
        #2;
        if (saw_l && l_left > 0) begin
            l_left--;
            if (l_left == 0) LReq = 1'b0;
        end
        if (saw_e && e_left > 0) begin
            e_left--;
            if (e_left == 0) begin EReq = 1'b0; ELock = 1'b0; end
        end
    endtask

    task automatic run(input int budget);
        int n;
        n = 0;
        while ((l_left > 0 || e_left > 0) && n < budget) begin
            step();
            n++;
        end
        check("run_timeout", 32'(l_left + e_left), 32'h0);
    endtask

    task automatic begin_test();
        step();
        step();
        l_done_q.delete(); e_done_q.delete();
        l_data_q.delete(); e_data_q.delete();
        sen_seen  = 1'b0;
        ssel_seen = 1'b0;
    endtask

    function automatic logic [31:0] qfirst(input int q[$], input int base);
        return (q.size() > 0) ? 32'(q[0] - base) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] qat(input int q[$], input int idx, input int base);
        return (q.size() > idx) ? 32'(q[idx] - base) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] dfirst(input logic [31:0] q[$]);
        return (q.size() > 0) ? q[0] : 32'hDEAD_DEAD;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_ = 1'b0; ECOn = 1'b0;
        LReq = 1'b0; LSel = '0; LWrite = 1'b0; LAddr = '0; LWData = '0;
        EReq = 1'b0; ESel = '0; EWrite = 1'b0; EAddr = '0; EWData = '0; ELock = 1'b0;
        SRData12 = '0; SRData13 = '0; SRData14 = '0;
        l_left = 0; e_left = 0;

        step();
        step();
        check("reset_owner", 32'(Owner), 32'h0);
        Reset_ = 1'b1;

        // Leon-only read from the DAC
        begin_test();
        ECOn = 1'b0; LSel = 3'b010; LWrite = 1'b0; LAddr = 32'h10; SRData13 = 32'hCAFE0001;
        l_left = 1; LReq = 1'b1; start = cyc;
        run(20);
        check("t1_ldone_lat", qfirst(l_done_q, start), 32'd3);
        check("t1_lrdata", dfirst(l_data_q), 32'hCAFE0001);

        // Leon write to the DSP returns zero read data
        begin_test();
        LSel = 3'b100; LWrite = 1'b1; LAddr = 32'h24; LWData = 32'hDEADBEEF; SRData14 = 32'h77778888;
        l_left = 1; LReq = 1'b1; start = cyc;
        run(20);
        check("t1b_ldone_lat", qfirst(l_done_q, start), 32'd3);
        check("t1b_lrdata", dfirst(l_data_q), 32'h0);

        // Simultaneous requests: EC first, Leon four cycles later
        begin_test();
        ECOn = 1'b1;
        LSel = 3'b001; LWrite = 1'b0; LAddr = 32'h100; SRData12 = 32'h11112222;
        ESel = 3'b100; EWrite = 1'b0; EAddr = 32'h200; SRData14 = 32'h33334444;
        l_left = 1; e_left = 1; LReq = 1'b1; EReq = 1'b1; start = cyc;
        run(30);
        check("t2_edone", qfirst(e_done_q, start), 32'd3);
        check("t2_ldone", qfirst(l_done_q, start), 32'd7);
        check("t2_erdata", dfirst(e_data_q), 32'h33334444);
        check("t2_lrdata", dfirst(l_data_q), 32'h11112222);

        // Starvation bound: two EC transfers, then Leon, then EC again
        begin_test();
        ESel = 3'b010; SRData13 = 32'h0BADF00D;
        l_left = 1; e_left = 3; LReq = 1'b1; EReq = 1'b1; start = cyc;
        run(40);
        check("t3_edone0", qat(e_done_q, 0, start), 32'd3);
        check("t3_edone1", qat(e_done_q, 1, start), 32'd7);
        check("t3_ldone",  qfirst(l_done_q, start), 32'd11);
        check("t3_edone2", qat(e_done_q, 2, start), 32'd15);

        // Lock: three EC transfers despite saturated wait, Leon after unlock
        begin_test();
        ELock = 1'b1;
        l_left = 1; e_left = 3; LReq = 1'b1; EReq = 1'b1; start = cyc;
        run(40);
        check("t4_edone2", qat(e_done_q, 2, start), 32'd11);
        check("t4_ldone",  qfirst(l_done_q, start), 32'd15);
        check("t4_ecount_before_l", 32'(e_done_q.size()), 32'd3);

        // Invalid select write: no slave select, strobe still pulses
        begin_test();
        ESel = 3'b011; EWrite = 1'b1; EAddr = 32'h40; EWData = 32'h55AA55AA;
        SRData12 = 32'h12121212; SRData13 = 32'h13131313;
        e_left = 1; EReq = 1'b1; start = cyc;
        run(20);
        check("t5_edone", qfirst(e_done_q, start), 32'd3);
        check("t5_erdata", dfirst(e_data_q), 32'h0);
        check("t5_senable_seen", 32'(sen_seen), 32'h1);
        check("t5_ssel_seen", 32'(ssel_seen), 32'h0);

        // EC disabled: EReq ignored, Leon served
        begin_test();
        ECOn = 1'b0; EWrite = 1'b0; ESel = 3'b001;
        LSel = 3'b001; LWrite = 1'b0; SRData12 = 32'hA5A5A5A5;
        l_left = 1; LReq = 1'b1; EReq = 1'b1; start = cyc;
        run(20);
        check("t6_ldone", qfirst(l_done_q, start), 32'd3);
        check("t6_no_edone", 32'(e_done_q.size()), 32'd0);
        EReq = 1'b0;

        // Asynchronous reset in the middle of ACCESS
        begin_test();
        LSel = 3'b001; LWrite = 1'b0; SRData12 = 32'h5EED5EED;
        l_left = 1; LReq = 1'b1;
        step();
        step();
        check("t7_pre_senable", 32'(SEnable), 32'h1);
        Reset_ = 1'b0;
        #1;
        check("t7_senable", 32'(SEnable), 32'h0);
        check("t7_ssel12",  32'(SSel12),  32'h0);
        check("t7_lgnt",    32'(LGnt),    32'h0);
        check("t7_ldone",   32'(LDone),   32'h0);
        step();
        Reset_ = 1'b1;
        l_done_q.delete(); l_data_q.delete();
        start = cyc;
        run(20);
        check("t7_ldone_lat", qfirst(l_done_q, start), 32'd3);
        check("t7_lrdata", dfirst(l_data_q), 32'h5EED5EED);

        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
